hart_debug_ctrl: RTL and testbench

HART_DEBUG_CTRL -- requirements
Module: hart_debug_ctrl

---
 rtl/hart_debug_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_hart_debug_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hart_debug_ctrl.sv
// Hart debug controller: halt/resume handshake with the core and abstract-command execution.
// Optional: define DEBUG_MEM_ACCESS_EN to build memory-access commands (cmdtype 2) and MEM_WAIT.
module hart_debug_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        resume_req,
    input  logic        exec,
    input  logic [31:0] command,
    input  logic [31:0] data0_in,
    input  logic [31:0] data1_in,
    output logic        halted,
    output logic        done,
    output logic        write,
    output logic        bus,
    output logic        haltresume,
    output logic        exception,
    output logic [31:0] data0_out,
    output logic        core_stall,
    input  logic        core_idle,
    input  logic [31:0] core_pc,
    output logic [31:0] resume_pc,
    output logic        core_resume,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_err,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [2:0] {
        RUN,
        HALTING,
        HALTED,
        EXEC,
`ifdef DEBUG_MEM_ACCESS_EN
        MEM_WAIT,
`endif
        RESUMING
    } state_t;

    state_t      state, state_next;
    logic        exec_stage, exec_armed;
    logic [7:0]  cmdtype_q;
    logic [2:0]  size_q;
    logic        transfer_q, write_q;
    logic [15:0] regno_q;
    logic [31:0] d0_q, dpc;
    logic        is_gpr, is_x0, is_dpc, reg_ok, mem_ok, finish, accept, reg_wr, reg_rd;
    logic        unused_cmd;

    assign unused_cmd = ^{command[23], command[19:18]};

`ifdef DEBUG_MEM_ACCESS_EN
    logic [31:0] d1_q;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_ack, mem_err, mem_rdata, data1_in};
`endif

    always_comb begin
        is_gpr = regno_q[15:5] == 11'h080;
        is_x0  = regno_q == 16'h1000;
        is_dpc = regno_q == 16'h07B1;
        reg_ok = (cmdtype_q == 8'd0) &&
                 (!transfer_q || ((size_q <= 3'd2) && (is_gpr || is_dpc)));
        mem_ok = 1'b0;
`ifdef DEBUG_MEM_ACCESS_EN
        mem_ok = (cmdtype_q == 8'd2) && (size_q <= 3'd2) &&
                 !((size_q == 3'd1 && d1_q[0]) || (size_q == 3'd2 && d1_q[1:0] != 2'b00));
`endif
        // Commands are decoded in the second EXEC cycle so done lands two cycles after exec.
        finish = (state == EXEC) && exec_stage;
        reg_wr = finish && reg_ok && transfer_q && write_q;
        reg_rd = finish && reg_ok && transfer_q && !write_q;
        accept = (state == HALTED) && exec && exec_armed;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:      if (halt_req) state_next = HALTING;
            HALTING:  if (core_idle) state_next = HALTED;
            HALTED: begin
                if (accept)          state_next = EXEC;
                else if (resume_req) state_next = RESUMING;
            end
            EXEC: begin
                if (exec_stage) begin
`ifdef DEBUG_MEM_ACCESS_EN
                    state_next = mem_ok ? MEM_WAIT : HALTED;
`else
                    state_next = HALTED;
`endif
                end
            end
`ifdef DEBUG_MEM_ACCESS_EN
            MEM_WAIT: if (mem_ack) state_next = HALTED;
`endif
            RESUMING: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    assign core_stall  = (state != RUN) && (state != RESUMING);
    assign halted      = core_stall && (state != HALTING);
    assign core_resume = state == RESUMING;
    assign resume_pc   = dpc;
    assign rf_addr     = regno_q[4:0];
    assign rf_wdata    = d0_q;
    assign rf_we       = reg_wr && is_gpr && !is_x0;

`ifdef DEBUG_MEM_ACCESS_EN
    assign mem_req   = state == MEM_WAIT;
    assign mem_we    = mem_req && write_q;
    assign mem_size  = mem_req ? size_q[1:0] : '0;
    assign mem_addr  = mem_req ? d1_q : '0;
    assign mem_wdata = mem_req ? d0_q : '0;
`else
    assign mem_req   = 1'b0;
    assign mem_we    = 1'b0;
    assign mem_size  = '0;
    assign mem_addr  = '0;
    assign mem_wdata = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            exec_stage <= 1'b0;
            exec_armed <= 1'b1;
            cmdtype_q  <= '0;
            size_q     <= '0;
            transfer_q <= 1'b0;
            write_q    <= 1'b0;
            regno_q    <= '0;
            d0_q       <= '0;
`ifdef DEBUG_MEM_ACCESS_EN
            d1_q       <= '0;
`endif
            dpc        <= '0;
            data0_out  <= '0;
            done       <= 1'b0;
            write      <= 1'b0;
            bus        <= 1'b0;
            exception  <= 1'b0;
            haltresume <= 1'b0;
        end else begin
            state      <= state_next;
            exec_stage <= (state == EXEC) && !exec_stage;
            done       <= 1'b0;
            write      <= 1'b0;
            bus        <= 1'b0;
            exception  <= 1'b0;
            haltresume <= ((state == HALTING) && core_idle) ||
                          ((state == HALTED) && (state_next == RESUMING));
            // A held exec runs once; it must drop before another command is accepted.
            if (accept) begin
                exec_armed <= 1'b0;
                cmdtype_q  <= command[31:24];
                size_q     <= command[22:20];
                transfer_q <= command[17];
                write_q    <= command[16];
                regno_q    <= command[15:0];
                d0_q       <= data0_in;
`ifdef DEBUG_MEM_ACCESS_EN
                d1_q       <= data1_in;
`endif
            end else if (!exec) begin
                exec_armed <= 1'b1;
            end
            if ((state == HALTING) && core_idle) dpc <= core_pc;
            if (reg_wr && is_dpc) dpc <= d0_q;
            if (finish && !mem_ok) begin
                done      <= 1'b1;
                exception <= !reg_ok;
            end
            if (reg_rd) begin
                write     <= 1'b1;
                data0_out <= is_dpc ? dpc : (is_x0 ? '0 : rf_rdata);
            end
`ifdef DEBUG_MEM_ACCESS_EN
            if ((state == MEM_WAIT) && mem_ack) begin
                done      <= 1'b1;
                bus       <= 1'b1;
                exception <= mem_err;
                if (!mem_err && !write_q) begin
                    data0_out <= mem_rdata;
                    write     <= 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_hart_debug_ctrl.sv
// Self-checking bench for hart_debug_ctrl: vector table, randomized commands vs a reference model,
// and hand sequences for halt, resume, memory access and reset corners.
module tb_hart_debug_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_req = 1'b0, resume_req = 1'b0, exec = 1'b0;
    logic [31:0] command = '0, data0_in = '0, data1_in = '0;
    logic        halted, done, write, bus, haltresume, exception;
    logic [31:0] data0_out;
    logic        core_stall, core_resume;
    logic        core_idle = 1'b0;
    logic [31:0] core_pc = '0, resume_pc;
    logic [4:0]  rf_addr;
    logic        rf_we;
    logic [31:0] rf_wdata, rf_rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = '0;

    hart_debug_ctrl dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .resume_req(resume_req), .exec(exec),
        .command(command), .data0_in(data0_in), .data1_in(data1_in),
        .halted(halted), .done(done), .write(write), .bus(bus), .haltresume(haltresume),
        .exception(exception), .data0_out(data0_out), .core_stall(core_stall),
        .core_idle(core_idle), .core_pc(core_pc), .resume_pc(resume_pc), .core_resume(core_resume),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_init(input int unsigned i);
        return (i == 5) ? 32'hDEADBEEF : 32'h1000_0000 + i * 32'h0101_0101;
    endfunction

    // Core register file seen by the DUT.
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf[rf_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state.
    logic [31:0] mrf [32];
    logic [31:0] mdpc, md0;

    function automatic void model(input logic [31:0] cmd, input logic [31:0] d0,
                                  output logic exc, output logic wr, output int nwe);
        int unsigned ctype = cmd[31:24];
        int unsigned sz    = cmd[22:20];
        int unsigned r     = cmd[15:0];
        exc = 1'b0; wr = 1'b0; nwe = 0;
        if (ctype != 0) exc = 1'b1;
        else if (cmd[17]) begin
            if (sz > 2) exc = 1'b1;
            else if (r >= 32'h1000 && r <= 32'h101F) begin
                if (cmd[16]) begin
                    if (r != 32'h1000) begin mrf[r - 32'h1000] = d0; nwe = 1; end
                end else begin
                    md0 = (r == 32'h1000) ? 32'h0 : mrf[r - 32'h1000];
                    wr = 1'b1;
                end
            end else if (r == 32'h07B1) begin
                if (cmd[16]) mdpc = d0;
                else begin md0 = mdpc; wr = 1'b1; end
            end else exc = 1'b1;
        end
    endfunction

    int          r_lat, r_nwe;
    logic        r_exc, r_wr, r_bus, r_memseen, r_mwe, r_after;
    logic [31:0] r_maddr, r_mwdata;
    logic [1:0]  r_msize;

    task automatic run_cmd(input logic [31:0] cmd, input logic [31:0] d0, input logic [31:0] d1,
                           input int ack_delay, input logic err, input logic [31:0] rdata);
        int mcnt = 0;
        command = cmd; data0_in = d0; data1_in = d1; mem_rdata = rdata; exec = 1'b1;
        r_lat = -1; r_nwe = 0; r_exc = 0; r_wr = 0; r_bus = 0; r_memseen = 0; r_mwe = 0;
        r_maddr = '0; r_mwdata = '0; r_msize = '0; r_after = 1'b1;
        tick();
        exec = 1'b0;
        for (int k = 1; k <= 30 && r_lat < 0; k++) begin
            tick();
            mem_ack = 1'b0; mem_err = 1'b0;
            if (rf_we) r_nwe++;
            if (mem_req) begin
                r_memseen = 1'b1; r_mwe = mem_we; r_maddr = mem_addr;
                r_mwdata = mem_wdata; r_msize = mem_size; mcnt++;
                if (mcnt == ack_delay) begin mem_ack = 1'b1; mem_err = err; end
            end
            if (done) begin r_lat = k; r_exc = exception; r_wr = write; r_bus = bus; end
        end
        tick();
        r_after = done;
    endtask

    task automatic do_halt(input logic [31:0] pc);
        halt_req = 1'b1; core_idle = 1'b0; core_pc = pc;
        tick();
        chk("halting_stall", core_stall, 1);
        chk("halting_not_halted", halted, 0);
        tick(); tick();
        chk("halting_wait", halted, 0);
        core_idle = 1'b1;
        tick();
        chk("halted_set", halted, 1);
        chk("halt_hr_pulse", haltresume, 1);
        halt_req = 1'b0; core_idle = 1'b0;
        tick();
        chk("halt_hr_drop", haltresume, 0);
        chk("halted_hold", halted, 1);
    endtask

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] d0;
        logic        exc;
        logic        wr;
        logic [31:0] data;
        int          nwe;
    } vec_t;
    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e, w, seen;
        int          n, cnt;
        logic [31:0] cmd, d0, prev;

        tbl[0]  = '{32'h00221005, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 0};
        tbl[1]  = '{32'h00221000, 32'h0,        1'b0, 1'b1, 32'h00000000, 0};
        tbl[2]  = '{32'h002207B1, 32'h0,        1'b0, 1'b1, 32'h80000040, 0};
        tbl[3]  = '{32'h00321005, 32'h0,        1'b1, 1'b0, 32'h80000040, 0};
        tbl[4]  = '{32'h00221020, 32'h0,        1'b1, 1'b0, 32'h80000040, 0};
        tbl[5]  = '{32'h01221005, 32'h0,        1'b1, 1'b0, 32'h80000040, 0};
        tbl[6]  = '{32'h00200000, 32'h0,        1'b0, 1'b0, 32'h80000040, 0};
        tbl[7]  = '{32'h00231007, 32'h55AA0001, 1'b0, 1'b0, 32'h80000040, 1};
        tbl[8]  = '{32'h00221007, 32'h0,        1'b0, 1'b1, 32'h55AA0001, 0};
        tbl[9]  = '{32'h00231000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h55AA0001, 0};
        tbl[10] = '{32'h00221000, 32'h0,        1'b0, 1'b1, 32'h00000000, 0};
        tbl[11] = '{32'h002307B1, 32'h00000200, 1'b0, 1'b0, 32'h00000000, 0};
        tbl[12] = '{32'h002207B1, 32'h0,        1'b0, 1'b1, 32'h00000200, 0};
        tbl[13] = '{32'h03221005, 32'h0,        1'b1, 1'b0, 32'h00000200, 0};
        for (int i = 0; i < 32; i++) mrf[i] = rf_init(i);
        mdpc = 32'h80000040; md0 = '0;

        // Reset state
        tick(); tick();
        chk("rst_halted", halted, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_done", done, 0);
        chk("rst_data0", data0_out, 0);
        chk("rst_resume_pc", resume_pc, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_rf_we", rf_we, 0);
        rst = 1'b0;
        tick();
        chk("run_idle_stall", core_stall, 0);

        do_halt(32'h80000040);

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].cmd, tbl[i].d0, e, w, n);
            run_cmd(tbl[i].cmd, tbl[i].d0, 32'h0, 0, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_latency", i), r_lat, 2);
            chk($sformatf("tbl%0d_pulse", i), r_after, 0);
            chk($sformatf("tbl%0d_exc", i), r_exc, tbl[i].exc);
            chk($sformatf("tbl%0d_write", i), r_wr, tbl[i].wr);
            chk($sformatf("tbl%0d_data0", i), data0_out, tbl[i].data);
            chk($sformatf("tbl%0d_rf_we", i), r_nwe, tbl[i].nwe);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0]  ct;
            logic [15:0] rg;
            logic [2:0]  jk;
            int unsigned sel = $urandom_range(0, 9);
            int unsigned rs  = $urandom_range(0, 3);
            jk = 3'($urandom);
`ifdef DEBUG_MEM_ACCESS_EN
            ct = (sel < 7) ? 8'd0 : 8'($urandom_range(3, 255));
`else
            ct = (sel < 6) ? 8'd0 : (sel < 8) ? 8'($urandom_range(3, 255)) : 8'd2;
`endif
            rg = (rs < 2) ? 16'(32'h1000 + $urandom_range(0, 31)) :
                 (rs == 2) ? 16'h07B1 : 16'($urandom);
            cmd = {ct, jk[0], 3'($urandom_range(0, 3)), jk[2:1],
                   ($urandom_range(0, 5) != 0), 1'($urandom), rg};
            d0 = $urandom;
            model(cmd, d0, e, w, n);
            run_cmd(cmd, d0, 32'h0, 0, 1'b0, 32'h0);
            chk($sformatf("rnd%0d_latency", i), r_lat, 2);
            chk($sformatf("rnd%0d_exc", i), r_exc, e);
            chk($sformatf("rnd%0d_write", i), r_wr, w);
            chk($sformatf("rnd%0d_data0", i), data0_out, md0);
            chk($sformatf("rnd%0d_rf_we", i), r_nwe, n);
        end

`ifdef DEBUG_MEM_ACCESS_EN
        run_cmd(32'h02210000, 32'h12345678, 32'h00001000, 4, 1'b0, 32'h0);
        chk("memwr_done", (r_lat > 0), 1);
        chk("memwr_bus", r_bus, 1);
        chk("memwr_exc", r_exc, 0);
        chk("memwr_we", r_mwe, 1);
        chk("memwr_addr", r_maddr, 32'h00001000);
        chk("memwr_wdata", r_mwdata, 32'h12345678);
        chk("memwr_size", r_msize, 2);
        chk("memwr_write", r_wr, 0);
        run_cmd(32'h02200000, 32'h0, 32'h00001002, 1, 1'b0, 32'h0);
        chk("misal_latency", r_lat, 2);
        chk("misal_exc", r_exc, 1);
        chk("misal_no_req", r_memseen, 0);
        run_cmd(32'h02100000, 32'h0, 32'h00002001, 1, 1'b0, 32'h0);
        chk("misal_half_exc", r_exc, 1);
        chk("misal_half_no_req", r_memseen, 0);
        prev = data0_out;
        run_cmd(32'h02200000, 32'h0, 32'h00002000, 2, 1'b1, 32'h11112222);
        chk("memerr_exc", r_exc, 1);
        chk("memerr_bus", r_bus, 1);
        chk("memerr_write", r_wr, 0);
        chk("memerr_data0", data0_out, prev);
        run_cmd(32'h02200000, 32'h0, 32'h00002004, 1, 1'b0, 32'hCAFEF00D);
        chk("memrd_exc", r_exc, 0);
        chk("memrd_write", r_wr, 1);
        chk("memrd_we", r_mwe, 0);
        chk("memrd_data0", data0_out, 32'hCAFEF00D);
`else
        run_cmd(32'h02210000, 32'h12345678, 32'h00001000, 1, 1'b0, 32'h0);
        chk("nomem_latency", r_lat, 2);
        chk("nomem_exc", r_exc, 1);
        chk("nomem_bus", r_bus, 0);
        chk("nomem_no_req", r_memseen, 0);
`endif

        // Held exec runs once; halt_req while halted is ignored
        command = 32'h00200000; exec = 1'b1; halt_req = 1'b1;
        cnt = 0; n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) cnt++;
            if (haltresume) n++;
        end
        chk("held_exec_once", cnt, 1);
        chk("halt_while_halted_hr", n, 0);
        chk("halt_while_halted", halted, 1);
        exec = 1'b0; halt_req = 1'b0;
        tick();

        run_cmd(32'h002307B1, 32'h00000200, 32'h0, 0, 1'b0, 32'h0);
        chk("dpc_wr_exc", r_exc, 0);
        resume_req = 1'b1;
        tick();
        resume_req = 1'b0;
        chk("resume_core_resume", core_resume, 1);
        chk("resume_pc", resume_pc, 32'h00000200);
        chk("resume_halted", halted, 0);
        chk("resume_hr", haltresume, 1);
        chk("resume_stall", core_stall, 0);
        tick();
        chk("resume_pulse_end", core_resume, 0);
        chk("resume_hr_end", haltresume, 0);
        resume_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (core_resume || halted) cnt++;
        end
        chk("resume_while_running", cnt, 0);
        resume_req = 1'b0;

        // Reset in the middle of a command
        do_halt(32'h00000300);
`ifdef DEBUG_MEM_ACCESS_EN
        command = 32'h02200000; data1_in = 32'h40; exec = 1'b1;
        tick();
        exec = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            seen = mem_req;
        end
        chk("rst_mem_wait_reached", seen, 1);
`else
        command = 32'h00221005; exec = 1'b1;
        tick();
        exec = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", mem_req, 0);
        chk("async_rst_halted", halted, 0);
        chk("async_rst_stall", core_stall, 0);
        chk("async_rst_data0", data0_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ack = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            mem_ack = 1'b0;
            if (done) cnt++;
        end
        chk("late_ack_no_done", cnt, 0);
        chk("late_ack_run", halted, 0);
        chk("late_ack_resume_pc", resume_pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
